gps_ack_peak: RTL and testbench
===============================

# gps_ack_peak

Post-processor sitting directly downstream of the acquisition correlator engine. Consumes the stream of per-bin correlation results (`corr_complete` strobes with satellite, code phase, Doppler and integrator value), tracks the strongest bin and a noise-floor sum for the current search, and on `search_complete` issues one detection record per satellite search over a valid/ready handshake to the tracking-channel allocator.

## Interface
- `THRESH`, 8'd40: detection ratio, unsigned Q4.4 (40 = 2.5× mean).
- `CNT_W`, 16: bin counter width; counter saturates at all-ones.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `corr_complete`  in  1: one-cycle strobe; the bin fields below are valid this cycle.
- `sat0`  in  6: PRN index of the bin.
- `code_phase`  in  10: code phase of the bin.
- `doppler_omega`  in  16 signed: Doppler NCO word of the bin.
- `integrator_0`  in  16: unsigned correlation magnitude.
- `search_complete`  in  1: one-cycle strobe closing the current search.
- `res_valid`  out  1: result record valid.
- `res_ready`  in  1: consumer accepts record when `res_valid & res_ready`.
- `res_sat`  out  6; `res_code_phase` out 10; `res_doppler` out 16 signed; `res_peak` out 16: best bin.
- `res_count`  out  CNT_W: bins accumulated.
- `res_detected`  out  1: threshold decision.
- `res_second`  out  16: second peak (see Configuration).
- `overflow`  out  1: sticky, a result was dropped; cleared only by `rst`.

## Operation
- States: COLLECT, MUL, DECIDE, HOLD. Reset state COLLECT.
- Accumulators (run in every state): `peak`, `peak_cp`, `peak_dop`, `sat_lat`, `sum` (32 b), `cnt`. On `corr_complete`: `sum += integrator_0`, `cnt` increments (saturating), `sat_lat <= sat0`; replace peak fields only if `integrator_0 > peak` (strict; first occurrence wins ties).
- COLLECT -> MUL on `search_complete`. A `corr_complete` in the same cycle is included in the snapshot. Snapshot copies all accumulators into result-side registers; accumulators clear to zero the same cycle so the next search starts clean.
- MUL: register `lhs = peak * cnt * 16` and `rhs = THRESH * sum`, both 40 b unsigned.
- DECIDE: `res_detected <= (cnt != 0) && (lhs >= rhs)`; -> HOLD, `res_valid <= 1`.
- HOLD: hold all `res_*` stable until handshake; on handshake `res_valid <= 0`, -> COLLECT.
- `search_complete` while not in COLLECT: snapshot not taken, accumulators still cleared, `overflow <= 1`.
- Empty search (`cnt == 0`): record issued with peak 0, detected 0.
- `rst` mid-operation: state COLLECT, all accumulators, `res_*`, `res_valid`, `overflow` to 0; pending record lost.

## Timing
- All outputs reset to 0.
- `search_complete` at cycle N -> `res_valid` high at N+3 (MUL at N+1, DECIDE at N+2).
- `res_ready` may be held high permanently; record accepted at N+3, next `search_complete` accepted from N+4.
- `res_*` change only on the DECIDE->HOLD edge; `res_valid` never drops without handshake.

## Configuration
- `GPS_ACK_PEAK_SECOND_EN` defined: also track `second`, largest integrator whose code phase differs from the current best by more than 2 (mod 1023 distance not applied; plain absolute difference). When a new best displaces the old one and the old is >2 chips away, old best moves to `second`. Snapshotted to `res_second`.
- Not defined: second-peak logic absent, `res_second` tied to 0.

## Test plan
- Single search, bins 100,300,120,300 (cp 5,9,12,20), then `search_complete`, ready high -> valid at N+3, peak 300 cp 9, count 4, sum 820, detected (300·4·16=19200 ≥ 40·820=32800 false) -> detected 0.
- Bins 50,50,50,800 -> 800·4·16=51200 ≥ 40·950=38000 -> detected 1, doppler of 4th bin.
- `corr_complete` coincident with `search_complete` -> bin included in count and peak.
- Ready low; second `search_complete` during HOLD -> first record unchanged, `overflow` = 1, following search's accumulators start from zero.
- `search_complete` with no bins -> record count 0, peak 0, detected 0.
- With `GPS_ACK_PEAK_SECOND_EN`: bins 200@cp10, 150@cp11, 180@cp40 -> peak 200, second 180; without macro second 0. `rst` asserted during MUL -> valid stays 0, all outputs 0.

Source files
------------

// File: rtl/gps_ack_peak_if.sv
// Bundles the correlator bin stream, the search strobe and the result
// handshake of gps_ack_peak. The correlator/allocator side uses the master
// modport; the post-processor uses the slave modport.
interface gps_ack_peak_if #(
   parameter int CNT_W = 16
);
   logic                corr_complete;
   logic [5:0]          sat0;
   logic [9:0]          code_phase;
   logic signed [15:0]  doppler_omega;
   logic [15:0]         integrator_0;
   logic                search_complete;

   logic                res_valid;
   logic                res_ready;
   logic [5:0]          res_sat;
   logic [9:0]          res_code_phase;
   logic signed [15:0]  res_doppler;
   logic [15:0]         res_peak;
   logic [CNT_W-1:0]    res_count;
   logic                res_detected;
   logic [15:0]         res_second;
   logic                overflow;

   modport master (
      output corr_complete, sat0, code_phase, doppler_omega, integrator_0,
             search_complete, res_ready,
      input  res_valid, res_sat, res_code_phase, res_doppler, res_peak,
             res_count, res_detected, res_second, overflow
   );

   modport slave (
      input  corr_complete, sat0, code_phase, doppler_omega, integrator_0,
             search_complete, res_ready,
      output res_valid, res_sat, res_code_phase, res_doppler, res_peak,
             res_count, res_detected, res_second, overflow
   );
endinterface

// File: rtl/gps_ack_peak.sv
// Acquisition post-processor: tracks the strongest correlation bin and the
// noise-floor sum of the current search, then issues one detection record
// per search over a valid/ready handshake.
// Optional feature: define GPS_ACK_PEAK_SECOND_EN to also track a second
// peak (res_second); otherwise res_second is tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | idle between records; a search_complete takes the snapshot
// MUL     | register peak*cnt*16 and THRESH*sum
// DECIDE  | compare products, load result record, raise res_valid
// HOLD    | record presented, wait for res_valid & res_ready
module gps_ack_peak #(
   parameter logic [7:0] THRESH = 8'd40,
   parameter int         CNT_W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   gps_ack_peak_if.slave bus
);

   typedef enum logic [1:0] {COLLECT, MUL, DECIDE, HOLD} state_t;

   state_t state_q, state_d;
   logic   snap_take;
   logic   snap_drop;
   logic   handshake;

   logic [15:0]       peak_q, peak_n;
   logic [9:0]        peak_cp_q, peak_cp_n;
   logic [15:0]       peak_dop_q, peak_dop_n;
   logic [5:0]        sat_lat_q, sat_lat_n;
   logic [31:0]       sum_q, sum_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;

   logic [15:0]       snap_peak;
   logic [9:0]        snap_cp;
   logic [15:0]       snap_dop;
   logic [5:0]        snap_sat;
   logic [31:0]       snap_sum;
   logic [CNT_W-1:0]  snap_cnt;

   logic [39:0]       lhs_q, rhs_q;

   logic              res_valid_q;
   logic [5:0]        res_sat_q;
   logic [9:0]        res_cp_q;
   logic [15:0]       res_dop_q;
   logic [15:0]       res_peak_q;
   logic [CNT_W-1:0]  res_cnt_q;
   logic              res_det_q;
   logic              overflow_q;

   assign handshake = res_valid_q & bus.res_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= COLLECT;
      else     state_q <= state_d;
   end

   // next-state decode; a search closed outside COLLECT is dropped
   always_comb begin
      state_d   = state_q;
      snap_take = 1'b0;
      snap_drop = bus.search_complete && (state_q != COLLECT);
      case (state_q)
         COLLECT: begin
            if (bus.search_complete) begin
               snap_take = 1'b1;
               state_d   = MUL;
            end
         end
         MUL:    state_d = DECIDE;
         DECIDE: state_d = HOLD;
         HOLD:   if (handshake) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // accumulator update for this cycle's bin; strict compare keeps first of ties
   always_comb begin
      peak_n     = peak_q;
      peak_cp_n  = peak_cp_q;
      peak_dop_n = peak_dop_q;
      sat_lat_n  = sat_lat_q;
      sum_n      = sum_q;
      cnt_n      = cnt_q;
      if (bus.corr_complete) begin
         sum_n     = sum_q + 32'(bus.integrator_0);
         cnt_n     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         sat_lat_n = bus.sat0;
         if (bus.integrator_0 > peak_q) begin
            peak_n     = bus.integrator_0;
            peak_cp_n  = bus.code_phase;
            peak_dop_n = bus.doppler_omega;
         end
      end
   end

   // accumulators clear on every search_complete so the next search starts clean
   always_ff @(posedge clk) begin
      if (rst || bus.search_complete) begin
         peak_q     <= '0;
         peak_cp_q  <= '0;
         peak_dop_q <= '0;
         sat_lat_q  <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
      end else begin
         peak_q     <= peak_n;
         peak_cp_q  <= peak_cp_n;
         peak_dop_q <= peak_dop_n;
         sat_lat_q  <= sat_lat_n;
         sum_q      <= sum_n;
         cnt_q      <= cnt_n;
      end
   end

   // snapshot includes a bin arriving in the same cycle as search_complete
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_peak <= '0;
         snap_cp   <= '0;
         snap_dop  <= '0;
         snap_sat  <= '0;
         snap_sum  <= '0;
         snap_cnt  <= '0;
      end else if (snap_take) begin
         snap_peak <= peak_n;
         snap_cp   <= peak_cp_n;
         snap_dop  <= peak_dop_n;
         snap_sat  <= sat_lat_n;
         snap_sum  <= sum_n;
         snap_cnt  <= cnt_n;
      end
   end

   // threshold products, registered to keep the multipliers off the compare path
   always_ff @(posedge clk) begin
      if (rst) begin
         lhs_q <= '0;
         rhs_q <= '0;
      end else if (state_q == MUL) begin
         lhs_q <= (40'(snap_peak) * 40'(snap_cnt)) << 4;
         rhs_q <= 40'(THRESH) * 40'(snap_sum);
      end
   end

   // result record: loaded only on DECIDE->HOLD, held until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_sat_q   <= '0;
         res_cp_q    <= '0;
         res_dop_q   <= '0;
         res_peak_q  <= '0;
         res_cnt_q   <= '0;
         res_det_q   <= 1'b0;
      end else if (state_q == DECIDE) begin
         res_valid_q <= 1'b1;
         res_sat_q   <= snap_sat;
         res_cp_q    <= snap_cp;
         res_dop_q   <= snap_dop;
         res_peak_q  <= snap_peak;
         res_cnt_q   <= snap_cnt;
         res_det_q   <= (snap_cnt != '0) && (lhs_q >= rhs_q);
      end else if (handshake) begin
         res_valid_q <= 1'b0;
      end
   end

   // sticky drop flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)            overflow_q <= 1'b0;
      else if (snap_drop) overflow_q <= 1'b1;
   end

`ifdef GPS_ACK_PEAK_SECOND_EN
   logic [15:0] second_q, second_n;
   logic [15:0] snap_second;
   logic [15:0] res_second_q;
   logic [9:0]  cp_dist;
   logic        cp_far;

   assign cp_dist = (bus.code_phase > peak_cp_q) ? (bus.code_phase - peak_cp_q)
                                                 : (peak_cp_q - bus.code_phase);
   assign cp_far  = cp_dist > 10'd2;

   // a displaced best far enough away becomes second; otherwise far bins compete
   always_comb begin
      second_n = second_q;
      if (bus.corr_complete) begin
         if (bus.integrator_0 > peak_q) begin
            if (cp_far) second_n = peak_q;
         end else if (cp_far && (bus.integrator_0 > second_q)) begin
            second_n = bus.integrator_0;
         end
      end
   end

   // second-peak accumulator, snapshot and result register
   always_ff @(posedge clk) begin
      if (rst) begin
         second_q     <= '0;
         snap_second  <= '0;
         res_second_q <= '0;
      end else begin
         second_q <= bus.search_complete ? 16'd0 : second_n;
         if (snap_take)          snap_second  <= second_n;
         if (state_q == DECIDE)  res_second_q <= snap_second;
      end
   end

   assign bus.res_second = res_second_q;
`else
   assign bus.res_second = '0;
`endif

   assign bus.res_valid      = res_valid_q;
   assign bus.res_sat        = res_sat_q;
   assign bus.res_code_phase = res_cp_q;
   assign bus.res_doppler    = res_dop_q;
   assign bus.res_peak       = res_peak_q;
   assign bus.res_count      = res_cnt_q;
   assign bus.res_detected   = res_det_q;
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_gps_ack_peak.sv
// Directed bench for gps_ack_peak: stimulus pushes hand-computed expected
// records into a queue; a monitor pops and compares on each accepted record.
module tb_gps_ack_peak;

`ifdef GPS_ACK_PEAK_SECOND_EN
   localparam bit SEC_EN = 1'b1;
`else
   localparam bit SEC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [5:0]  sat;
      logic [9:0]  cp;
      logic [15:0] dop;
      logic [15:0] peak;
      logic [15:0] cnt;
      logic        det;
      logic [15:0] sec;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;
   rec_t exp_q[$];

   gps_ack_peak_if #(.CNT_W(16)) bus ();

   gps_ack_peak #(.THRESH(8'd40), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic bin(input logic [5:0] s, input logic [9:0] cp, input logic [15:0] d,
                      input logic [15:0] m);
      bus.sat0          = s;
      bus.code_phase    = cp;
      bus.doppler_omega = d;
      bus.integrator_0  = m;
      bus.corr_complete = 1'b1;
      @(posedge clk); #1;
      bus.corr_complete = 1'b0;
   endtask

   task automatic search();
      bus.search_complete = 1'b1;
      @(posedge clk); #1;
      bus.search_complete = 1'b0;
   endtask

   task automatic push_exp(input logic [5:0] s, input logic [9:0] cp, input logic [15:0] d,
                           input logic [15:0] pk, input logic [15:0] cnt, input logic det,
                           input logic [15:0] sec);
      rec_t e;
      e.sat  = s;
      e.cp   = cp;
      e.dop  = d;
      e.peak = pk;
      e.cnt  = cnt;
      e.det  = det;
      e.sec  = SEC_EN ? sec : 16'd0;
      exp_q.push_back(e);
   endtask

   // bounded wait for res_valid; latency counted in rising edges after search()
   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.res_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'd2);
   endtask

   task automatic run_search(input string name);
      search();
      wait_valid(name);
      if (bus.res_ready) begin
         @(posedge clk); #1;
         check({name, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
      end
   endtask

   // monitor: compare each record at the edge where it is accepted
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("rec_sat",  64'(bus.res_sat),               64'(e.sat));
               check("rec_cp",   64'(bus.res_code_phase),        64'(e.cp));
               check("rec_dop",  64'($unsigned(bus.res_doppler)), 64'(e.dop));
               check("rec_peak", 64'(bus.res_peak),              64'(e.peak));
               check("rec_cnt",  64'(bus.res_count),             64'(e.cnt));
               check("rec_det",  64'(bus.res_detected),          64'(e.det));
               check("rec_sec",  64'(bus.res_second),            64'(e.sec));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bus.corr_complete   = 1'b0;
      bus.sat0            = '0;
      bus.code_phase      = '0;
      bus.doppler_omega   = '0;
      bus.integrator_0    = '0;
      bus.search_complete = 1'b0;
      bus.res_ready       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_valid",    64'(bus.res_valid),    64'd0);
      check("rst_overflow", 64'(bus.overflow),     64'd0);
      check("rst_peak",     64'(bus.res_peak),     64'd0);
      check("rst_count",    64'(bus.res_count),    64'd0);
      check("rst_detected", 64'(bus.res_detected), 64'd0);

      // mean-level peak: 19200 < 32800 -> not detected
      bus.res_ready = 1'b1;
      bin(6'd3, 10'd5,  16'sd10,  16'd100);
      bin(6'd3, 10'd9,  -16'sd20, 16'd300);
      bin(6'd3, 10'd12, 16'sd30,  16'd120);
      bin(6'd7, 10'd20, 16'sd40,  16'd300);
      push_exp(6'd7, 10'd9, -16'sd20, 16'd300, 16'd4, 1'b0, 16'd300);
      run_search("t1");

      // strong peak: 51200 >= 38000 -> detected
      bin(6'd1, 10'd1, -16'sd5,    16'd50);
      bin(6'd1, 10'd2, -16'sd6,    16'd50);
      bin(6'd1, 10'd3, -16'sd7,    16'd50);
      bin(6'd1, 10'd4, -16'sd1234, 16'd800);
      push_exp(6'd1, 10'd4, -16'sd1234, 16'd800, 16'd4, 1'b1, 16'd50);
      run_search("t2");

      // bin coincident with search_complete is part of the record
      bin(6'd4, 10'd100, 16'sd5, 16'd10);
      bus.sat0            = 6'd9;
      bus.code_phase      = 10'd200;
      bus.doppler_omega   = 16'sd77;
      bus.integrator_0    = 16'd500;
      bus.corr_complete   = 1'b1;
      push_exp(6'd9, 10'd200, 16'sd77, 16'd500, 16'd2, 1'b0, 16'd10);
      search();
      bus.corr_complete   = 1'b0;
      wait_valid("t3");
      @(posedge clk); #1;
      check("t3_valid_drop", 64'(bus.res_valid), 64'd0);

      // consumer stalled: second search during HOLD is dropped
      bus.res_ready = 1'b0;
      bin(6'd2, 10'd7, 16'sd11, 16'd1000);
      push_exp(6'd2, 10'd7, 16'sd11, 16'd1000, 16'd1, 1'b0, 16'd0);
      search();
      wait_valid("t4");
      bin(6'd5, 10'd3, 16'sd9, 16'd60000);
      search();
      @(posedge clk); #1;
      check("t4_overflow",   64'(bus.overflow),  64'd1);
      check("t4_hold_valid", 64'(bus.res_valid), 64'd1);
      check("t4_hold_peak",  64'(bus.res_peak),  64'd1000);
      check("t4_hold_count", 64'(bus.res_count), 64'd1);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_valid_drop", 64'(bus.res_valid), 64'd0);
      bin(6'd1, 10'd50, -16'sd3, 16'd20);
      push_exp(6'd1, 10'd50, -16'sd3, 16'd20, 16'd1, 1'b0, 16'd0);
      run_search("t4b");
      check("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

      // empty search
      push_exp(6'd0, 10'd0, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0);
      run_search("t5");

      // second-peak pattern
      bin(6'd12, 10'd10, 16'sd1, 16'd200);
      bin(6'd12, 10'd11, 16'sd2, 16'd150);
      bin(6'd12, 10'd40, 16'sd3, 16'd180);
      push_exp(6'd12, 10'd10, 16'sd1, 16'd200, 16'd3, 1'b0, 16'd180);
      run_search("t6");

      // exact threshold 8000 == 8000 detects; tie keeps first bin
      bin(6'd20, 10'd30, -16'sd1, 16'd100);
      bin(6'd20, 10'd31, -16'sd2, 16'd100);
      bin(6'd20, 10'd32, 16'sd0,  16'd0);
      bin(6'd20, 10'd33, 16'sd0,  16'd0);
      bin(6'd20, 10'd34, 16'sd0,  16'd0);
      push_exp(6'd20, 10'd30, -16'sd1, 16'd100, 16'd5, 1'b1, 16'd0);
      run_search("t7");

      // reset while in MUL: record lost, everything back to zero
      search();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.res_valid) seen++;
      end
      check("t8_no_valid",  64'(seen),                        64'd0);
      check("t8_overflow",  64'(bus.overflow),                64'd0);
      check("t8_peak",      64'(bus.res_peak),                64'd0);
      check("t8_count",     64'(bus.res_count),               64'd0);
      check("t8_cp",        64'(bus.res_code_phase),          64'd0);
      check("t8_dop",       64'($unsigned(bus.res_doppler)),  64'd0);
      check("t8_sat",       64'(bus.res_sat),                 64'd0);
      check("t8_detected",  64'(bus.res_detected),            64'd0);
      check("t8_second",    64'(bus.res_second),              64'd0);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
